// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: datapath widths, ALU op codes, memory op codes
// and the MEM-stage state encoding.
package mem_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // Byte count of an access; 0 means "not a memory op" (undefined codes included).
    function automatic logic [2:0] memop_bytes(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: memop_bytes = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: memop_bytes = 3'd2;
            MEM_LW, MEM_SW:          memop_bytes = 3'd4;
            default:                 memop_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        memop_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatting: picks the significant lanes of the assembled load
// buffer and sign- or zero-extends them to a full register word.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] lbuf_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = '0;
        case (op_i)
            MEM_LB:  data_o = {{24{lbuf_i[7]}}, lbuf_i[7:0]};
            MEM_LH:  data_o = {{16{lbuf_i[15]}}, lbuf_i[15:0]};
            MEM_LW:  data_o = lbuf_i;
            MEM_LBU: data_o = {24'b0, lbuf_i[7:0]};
            MEM_LHU: data_o = {16'b0, lbuf_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: serialises loads/stores into byte transfers on a simple
// req/ack bus and stalls the pipeline until the result is ready.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_ACK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [3:0]        memop_i,
    input  logic [XLEN-1:0]   sdata_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic              mem_we_o,
    output logic [BYTE_W-1:0] mem_dout_o,
    input  logic [BYTE_W-1:0] mem_din_i,
    input  logic              mem_ack_i,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              mem_stall_o,
    output logic              bus_err_o
);

    localparam logic [31:0] ACK_TO = 32'(MEM_ACK_TIMEOUT);

    mem_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] sdata_q, sdata_d;
    logic [XLEN-1:0] lbuf_q, lbuf_d;
    logic            bus_err_q, bus_err_d;
    logic [31:0]     tmr_q, tmr_d;

    logic [2:0]      in_bytes;
    logic [2:0]      op_bytes;
    logic            last_byte;
    logic [XLEN-1:0] ext_data;

    assign in_bytes  = memop_bytes(memop_i);
    assign op_bytes  = memop_bytes(op_q);
    assign last_byte = (3'(cnt_q) + 3'd1) == op_bytes;

    mem_load_ext u_load_ext (
        .op_i   (op_q),
        .lbuf_i (lbuf_q),
        .data_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            op_q      <= MEM_NONE;
            sdata_q   <= '0;
            lbuf_q    <= '0;
            bus_err_q <= 1'b0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            sdata_q   <= sdata_d;
            lbuf_q    <= lbuf_d;
            bus_err_q <= bus_err_d;
            tmr_q     <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_d      = op_q;
        sdata_d   = sdata_q;
        lbuf_d    = lbuf_q;
        bus_err_d = bus_err_q;
        tmr_d     = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_bytes != 3'd0) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    addr_d  = wdata_i;
                    op_d    = memop_i;
                    sdata_d = sdata_i;
                    lbuf_d  = '0;
                    tmr_d   = ACK_TO;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    if (!memop_is_store(op_q)) begin
                        lbuf_d[{cnt_q, 3'b000} +: BYTE_W] = mem_din_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                    tmr_d = ACK_TO;
                    if (last_byte) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    // Down-counter reloaded per byte; a timeout of 0 never reaches 1.
                    if (tmr_q == 32'd1) begin
                        bus_err_d = 1'b1;
                    end
                    if (tmr_q != 32'd0) begin
                        tmr_d = tmr_q - 32'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_dout_o  = '0;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        mem_stall_o = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    wd_o = wd_i;
                    if (in_bytes == 3'd0) begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else begin
                        mem_stall_o = 1'b1;
                    end
                end
                ST_ACCESS: begin
                    mem_req_o   = 1'b1;
                    mem_addr_o  = addr_q + 32'(cnt_q);
                    mem_we_o    = memop_is_store(op_q);
                    mem_dout_o  = sdata_q[{cnt_q, 3'b000} +: BYTE_W];
                    mem_stall_o = 1'b1;
                    wd_o        = wd_i;
                end
                ST_DONE: begin
                    wd_o = wd_i;
                    if (!memop_is_store(op_q)) begin
                        wreg_o  = wreg_i;
                        wdata_o = ext_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random loads/stores against a
// byte-addressed memory model and a per-op expected-result model.
module tb_mem_stage;

    localparam int TO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  memop_i;
    logic [31:0] sdata_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [7:0]  mem_dout_o;
    logic [7:0]  mem_din_i;
    logic        mem_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        mem_stall_o;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;
    logic model_err = 1'b0;
    logic [7:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_stage #(.MEM_ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .memop_i(memop_i), .sdata_i(sdata_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_dout_o(mem_dout_o),
        .mem_din_i(mem_din_i), .mem_ack_i(mem_ack_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .mem_stall_o(mem_stall_o), .bus_err_o(bus_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] v);
        case (op)
            4'd1:    return 32'($signed(v[7:0]));
            4'd2:    return 32'($signed(v[15:0]));
            4'd4:    return v & 32'h0000_00FF;
            4'd5:    return v & 32'h0000_FFFF;
            default: return v;
        endcase
    endfunction

    // Presents one op (positioned just after a falling edge) and follows it to completion.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] wd, input logic wr, input int hold_byte,
                          input int hold_cycles, input bit rand_wait);
        int n;
        bit st;
        int waits;
        logic [31:0] a;
        logic [31:0] acc;
        logic [7:0] b;
        n  = nbytes(op);
        st = (op >= 4'd6) && (op <= 4'd8);
        memop_i = op; wdata_i = addr; sdata_i = sd; wd_i = wd; wreg_i = wr;
        mem_ack_i = 1'b0;
        #1;
        if (n == 0) begin
            check("pass_wdata", wdata_o, addr);
            check("pass_wreg", 32'(wreg_o), 32'(wr));
            check("pass_wd", 32'(wd_o), 32'(wd));
            check("pass_stall", 32'(mem_stall_o), 0);
            check("pass_req", 32'(mem_req_o), 0);
            cyc();
            return;
        end
        check("idle_stall", 32'(mem_stall_o), 1);
        check("idle_req", 32'(mem_req_o), 0);
        cyc();
        acc = 0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            if (k == hold_byte) waits = hold_cycles;
            else if (rand_wait) waits = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 1));
            else waits = 0;
            if (waits >= TO) model_err = 1'b1;
            b = 8'((sd >> (8 * k)) & 32'hFF);
            for (int w = 0; w <= waits; w++) begin
                check("acc_req", 32'(mem_req_o), 1);
                check("acc_addr", mem_addr_o, a);
                check("acc_we", 32'(mem_we_o), 32'(st));
                check("acc_stall", 32'(mem_stall_o), 1);
                if (st) check("acc_dout", 32'(mem_dout_o), 32'(b));
                if (w == waits) begin
                    mem_ack_i = 1'b1;
                    if (st) mem[a] = b;
                    else begin
                        mem_din_i = rd(a);
                        acc = acc | (32'(rd(a)) << (8 * k));
                    end
                end else begin
                    mem_ack_i = 1'b0;
                    mem_din_i = 8'($urandom);
                end
                cyc();
                mem_ack_i = 1'b0;
            end
        end
        check("done_req", 32'(mem_req_o), 0);
        check("done_stall", 32'(mem_stall_o), 0);
        check("done_wd", 32'(wd_o), 32'(wd));
        check("done_wreg", 32'(wreg_o), st ? 0 : 32'(wr));
        check("done_wdata", wdata_o, st ? 32'h0 : extend(op, acc));
        check("bus_err", 32'(bus_err_o), 32'(model_err));
        cyc();
    endtask

    initial begin
        rst = 1'b1; memop_i = 4'd3; wdata_i = 32'hDEAD_BEEF; sdata_i = 32'h1234_5678;
        wd_i = 5'd7; wreg_i = 1'b1; mem_din_i = 8'h00; mem_ack_i = 1'b0;
        cyc(); cyc();
        check("rst_req", 32'(mem_req_o), 0);
        check("rst_we", 32'(mem_we_o), 0);
        check("rst_stall", 32'(mem_stall_o), 0);
        check("rst_wreg", 32'(wreg_o), 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_wd", 32'(wd_o), 0);
        check("rst_buserr", 32'(bus_err_o), 0);
        memop_i = 4'd0;
        @(negedge clk);
        rst = 1'b0;

        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(4'd3, 32'h100, 32'h0, 5'd3, 1'b1, -1, 0, 0);
        mem[32'h20] = 8'h80;
        run_op(4'd1, 32'h20, 32'h0, 5'd4, 1'b1, -1, 0, 0);
        run_op(4'd4, 32'h20, 32'h0, 5'd5, 1'b1, -1, 0, 0);
        run_op(4'd7, 32'h202, 32'h0000_ABCD, 5'd6, 1'b1, -1, 0, 0);
        check("sh_lo", 32'(rd(32'h202)), 32'hCD);
        check("sh_hi", 32'(rd(32'h203)), 32'hAB);
        run_op(4'd0, 32'h55, 32'h0, 5'd8, 1'b1, -1, 0, 0);
        run_op(4'd12, 32'h77, 32'h0, 5'd9, 1'b1, -1, 0, 0);
        run_op(4'd3, 32'hFFFF_FFFE, 32'h0, 5'd10, 1'b1, -1, 0, 0);
        run_op(4'd3, 32'h100, 32'h0, 5'd11, 1'b1, 1, 3, 0);
        check("err_sticky", 32'(bus_err_o), 1);

        // Reset after two of four load bytes: no DONE pulse, back to IDLE.
        memop_i = 4'd3; wdata_i = 32'h300; wd_i = 5'd12; wreg_i = 1'b1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            check("rst_mid_addr", mem_addr_o, 32'h300 + 32'(k));
            mem_ack_i = 1'b1; mem_din_i = rd(32'h300 + 32'(k));
            cyc();
        end
        mem_ack_i = 1'b0; rst = 1'b1;
        cyc();
        check("rst_mid_req", 32'(mem_req_o), 0);
        check("rst_mid_wreg", 32'(wreg_o), 0);
        rst = 1'b0; memop_i = 4'd0; wdata_i = 32'h99; model_err = 1'b0;
        #1;
        check("rst_mid_idle", wdata_o, 32'h99);
        check("rst_mid_stall", 32'(mem_stall_o), 0);
        check("rst_mid_buserr", 32'(bus_err_o), 0);
        cyc();

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ad;
            ad = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'h400 + 32'($urandom_range(0, 63));
            run_op(4'($urandom_range(0, 15)), ad, $urandom, 5'($urandom), 1'($urandom),
                   -1, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
